muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer for the Execution stage. It accepts one M-extension operation at a time from the Ex-stage operand muxes (post-forwarding operands), runs a fixed-latency radix-2 shift-add multiply or restoring divide over 32 iterations, and returns a 32-bit result. While the operation is in flight it holds `busy`, which drives the Ex-stage `Exnow` stall output, so the pipeline freezes until `done`.

---
 rtl/muldiv_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV32M multiply/divide sequencer for the Execution stage. One
// M-extension operation is accepted at a time. It runs for a fixed latency
// using a radix-2 shift-add multiply or a restoring divide. The pipeline is
// held through `busy` while the operation is in flight.
//
// Handshake: `start` is sampled only in IDLE and only when `flush` is low.
// The cycle in which it is sampled is the accept cycle. `busy` rises
// combinationally in that cycle and stays high through CALC and FIX. It drops
// in DONE, the same cycle `done` pulses for one clock with `result` valid. The
// requester may keep `start` high while stalled, because `start` is ignored
// outside IDLE.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; returns to IDLE, clears outputs
//   flush      synchronous abort; returns to IDLE without a `done` pulse
//   start      operation request, sampled in IDLE
//   op         RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b       rs1 / rs2 operands, sampled with `start`
//   result     registered result, held until the next completion
//   busy       stall request to the Ex stage (only combinational output)
//   done       one-cycle completion pulse
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_a_q, neg_a_d;     // rs1 was negative and signed
    logic                 neg_b_q, neg_b_d;     // rs2 was negative and signed
    logic [2*WIDTH-1:0]   acc_q, acc_d;         // product, or remainder:quotient
    logic [WIDTH-1:0]     opnd_q, opnd_d;       // |b|: multiplicand or divisor
    logic [WIDTH-1:0]     a_orig_q, a_orig_d;   // raw rs1 for REM-by-zero
    logic                 b_zero_q, b_zero_d;
    logic                 ovf_q, ovf_d;         // MIN_NEG / -1 operand pair
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 done_q, done_d;

    // ---------------------------------------------------------------------
    // Operand conditioning in the accept cycle
    // ---------------------------------------------------------------------
    logic             a_signed;
    logic             b_signed;
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV)  || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        in_neg_a = a_signed & a[WIDTH-1];
        in_neg_b = b_signed & b[WIDTH-1];
        // Negating MIN_NEG wraps back to MIN_NEG. As an unsigned magnitude,
        // that is exactly 2^(WIDTH-1).
        abs_a    = in_neg_a ? ('0 - a) : a;
        abs_b    = in_neg_b ? ('0 - b) : b;
    end

    // ---------------------------------------------------------------------
    // One iteration of multiply / divide
    // ---------------------------------------------------------------------
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_step;

    always_comb begin
        // Shift-add: the carry out of the upper-half add becomes the new MSB
        // after the right shift.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        // Restoring divide: the remainder after the left shift is one bit
        // wider than the divisor. The trial is therefore taken on WIDTH+1 bits.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_trial >= {1'b0, opnd_q};
        div_rem   = WIDTH'(div_trial - {1'b0, opnd_q});
        div_step  = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};
    end

    // ---------------------------------------------------------------------
    // Sign correction, result selection and special cases
    // ---------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_val;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? ('0 - acc_q) : acc_q;
        quot_fix = (neg_a_q ^ neg_b_q) ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        // The remainder follows the sign of the dividend.
        rem_fix  = neg_a_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

        fix_val = '0;
        if (!op_q[2]) begin
            // MUL keeps the low half. The three MULH variants keep the high half.
            fix_val = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                           : prod_fix[2*WIDTH-1:WIDTH];
        end else if (b_zero_q) begin
            fix_val = op_q[1] ? a_orig_q : ALL_ONES;
        end else if (ovf_q && !op_q[0]) begin
            // Signed overflow: the quotient saturates to MIN_NEG and the
            // remainder is zero.
            fix_val = op_q[1] ? '0 : MIN_NEG;
        end else begin
            fix_val = op_q[1] ? rem_fix : quot_fix;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic. `flush` overrides every transition.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_CALC;
                ST_CALC: if (cnt_q == LAST_ITER) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs. `busy` is gated by reset so that it also reads 0 while
    // reset is held with `start` high.
    // ---------------------------------------------------------------------
    always_comb begin
        busy = !reset && (((state_q == ST_IDLE) && start && !flush) ||
                          (state_q == ST_CALC) || (state_q == ST_FIX));
        done      = done_q;
        result    = result_q;
        dbg_state = state_q;
    end

    // ---------------------------------------------------------------------
    // Datapath next-value logic
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        b_zero_d = b_zero_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        // `done` pulses in the cycle after FIX unless that FIX was flushed.
        done_d   = (state_q == ST_FIX) && !flush;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d     = op;
                    neg_a_d  = in_neg_a;
                    neg_b_d  = in_neg_b;
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    opnd_d   = abs_b;
                    a_orig_d = a;
                    b_zero_d = (b == '0);
                    ovf_d    = (a == MIN_NEG) && (b == ALL_ONES);
                    cnt_d    = '0;
                end
            end
            ST_CALC: begin
                acc_d = op_q[2] ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
            end
            ST_FIX: begin
                if (!flush) result_d = fix_val;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            b_zero_q <= b_zero_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//
// Directed and randomized bench for muldiv_seq. Expected results come either
// from constants or from a reference function. The function is written with
// plain 64-bit and 32-bit arithmetic operators. Completions are matched
// against an expected queue in order.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_CALC = 32'd1;
    localparam logic [31:0] ST_FIX  = 32'd2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int          n_cmp;
    int          n_fail;
    int          done_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------------
    // Clock and watchdog
    // ---------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Count done pulses, one per cycle that done is high.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic logic [31:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        longint p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        r  = '0;
        case (o)
            OP_MUL:    begin p = sx * sy; r = p[31:0];  end
            OP_MULH:   begin p = sx * sy; r = p[63:32]; end
            OP_MULHSU: begin p = sx * uy; r = p[63:32]; end
            OP_MULHU:  begin p = ux * uy; r = p[63:32]; end
            OP_DIV: begin
                if (y == 32'd0)                                r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else                                           r = $signed(x) / $signed(y);
            end
            OP_DIVU: begin
                if (y == 32'd0) r = 32'hFFFF_FFFF;
                else            r = x / y;
            end
            OP_REM: begin
                if (y == 32'd0)                                r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                else                                           r = $signed(x) % $signed(y);
            end
            default: begin
                if (y == 32'd0) r = x;
                else            r = x % y;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 255));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Checker
    // ---------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver: one full operation from accept to the IDLE cycle after DONE.
    // Call it at 1 ns after a rising edge with the DUT in IDLE.
    // ---------------------------------------------------------------------
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expv,
                          input bit hold);
        int          d0;
        logic [31:0] want;
        d0    = done_cnt;
        op    = o;
        a     = x;
        b     = y;
        flush = 1'b0;
        start = 1'b1;
        exp_q.push_back(expv);
        #1;
        chk("busy_accept", 32'(busy), 32'd1);
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            // Operands may change once accepted. The stalled requester may
            // keep start high.
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            if (!hold) start = 1'b0;
            if (k == 1)  chk("state_calc", 32'(dbg_state), ST_CALC);
            if (k == 33) chk("state_fix", 32'(dbg_state), ST_FIX);
            if (k < 34) begin
                chk("busy_inflight", 32'(busy), 32'd1);
                chk("done_early", 32'(done), 32'd0);
            end else begin
                chk("done_n34", 32'(done), 32'd1);
                chk("busy_n34", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL sb_empty: observed %h expected queued value", result);
                end else begin
                    want = exp_q.pop_front();
                    chk("result", result, want);
                    last_res = want;
                end
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_n35", 32'(done), 32'd0);
        chk("state_n35", 32'(dbg_state), ST_IDLE);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int          d0;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        n_cmp    = 0;
        n_fail   = 0;
        done_cnt = 0;
        last_res = '0;
        reset    = 1'b1;
        flush    = 1'b0;
        start    = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), ST_IDLE);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Multiply
        run_op(OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        run_op(OP_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op(OP_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);

        // Divide
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_DIVU, 32'd100,       32'd7, 32'd14,        1'b0);
        run_op(OP_REMU, 32'd100,       32'd7, 32'd2,         1'b0);

        // Divide by zero and signed overflow
        run_op(OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
        run_op(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

        // Flush at N+10 of a DIV, then a new start at N+12
        d0    = done_cnt;
        op    = OP_DIV;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        #1;
        chk("flush_accept_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_state", 32'(dbg_state), ST_IDLE);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result_kept", result, last_res);
        @(posedge clk);
        #1;
        chk("flush_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0);

        // start together with flush in IDLE is not accepted
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MUL;
        a     = 32'd5;
        b     = 32'd6;
        #1;
        chk("sf_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("sf_state1", 32'(dbg_state), ST_IDLE);
        @(posedge clk);
        #1;
        chk("sf_state2", 32'(dbg_state), ST_IDLE);
        start = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC
        d0    = done_cnt;
        op    = OP_MUL;
        a     = 32'd123;
        b     = 32'd456;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_state", 32'(dbg_state), ST_CALC);
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_state", 32'(dbg_state), ST_IDLE);
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_res = '0;
        @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678,
               ref_model(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 1'b1);

        // Randomized operations against the reference model
        for (int i = 0; i < 48; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb, ref_model(ro, ra, rb), 1'($urandom_range(0, 1)));
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
